// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, fixed WIDTH-cycle latency.
// Define DIV_ZERO_FAST_EN to finish B=0 requests in one cycle and raise div_by_zero.
module restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] dvd_nxt;
    logic             last_step;
    logic             fast_zero;
    logic             accept;

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = (B == '0);
`else
    assign fast_zero = 1'b0;
`endif

    assign accept    = (state == IDLE) && start;
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    // One restoring step: dvd_q doubles as the quotient shift register as dividend bits leave it.
    always_comb begin
        shifted = {rem_q, dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dsr_q};
        q_bit   = ~trial[WIDTH];
        rem_nxt = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_nxt = {dvd_q[WIDTH-2:0], q_bit};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first so no path through this block leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = fast_zero ? DONE : RUN;
            RUN:  if (last_step) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            if (accept) begin
                dvd_q <= A;
                dsr_q <= B;
                rem_q <= '0;
                cnt_q <= '0;
                if (fast_zero) begin
                    quotient  <= '1;
                    remainder <= A;
                end
            end else if (state == RUN) begin
                rem_q <= rem_nxt;
                dvd_q <= dvd_nxt;
                cnt_q <= cnt_q + CW'(1);
                // Results are published only on the final step and held through IDLE.
                if (last_step) begin
                    quotient  <= dvd_nxt;
                    remainder <= rem_nxt;
                end
            end
        end
    end

`ifdef DIV_ZERO_FAST_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            div_by_zero <= 1'b0;
        end else if (accept) begin
            div_by_zero <= fast_zero;
        end
    end
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_divider.sv
// Directed testbench for restoring_divider (WIDTH=8); expectations adapt to DIV_ZERO_FAST_EN.
module tb_restoring_divider;

    logic       Clock;
    logic       Resetn;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    restoring_divider #(.WIDTH(8)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .start       (start),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " quotient"}, 32'(quotient), 32'd0);
        check({tag, " remainder"}, 32'(remainder), 32'd0);
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'd0);
    endtask

    // Launch one division; with poke set, start is pulsed and operands are trashed
    // during RUN, and start is held high in the DONE cycle.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic edz,
                          input bit poke);
        int lat;
        lat = 8;
`ifdef DIV_ZERO_FAST_EN
        if (b == 8'd0) lat = 0;
`endif
        A = a;
        B = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check($sformatf("%s busy@%0d", tag, i + 1), 32'(busy), 32'd1);
            check($sformatf("%s nodone@%0d", tag, i + 1), 32'(done), 32'd0);
            if (poke) begin
                start = 1'b1;
                A = 8'hFF;
                B = 8'hFF;
            end
            tick();
        end
        start = poke;
        check({tag, " done busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
        tick();
        start = 1'b0;
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle done"}, 32'(done), 32'd0);
        check({tag, " hold quotient"}, 32'(quotient), 32'(eq));
        check({tag, " hold remainder"}, 32'(remainder), 32'(er));
        tick();
        check({tag, " idle2 busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic dz_exp;
`ifdef DIV_ZERO_FAST_EN
        dz_exp = 1'b1;
`else
        dz_exp = 1'b0;
`endif
        Resetn = 1'b0;
        start  = 1'b0;
        A      = 8'd0;
        B      = 8'd0;
        #1;
        check_all_zero("reset t0");
        start = 1'b1;
        tick();
        tick();
        check_all_zero("reset clocked");
        start  = 1'b0;
        Resetn = 1'b1;
        tick();
        check_all_zero("post reset");

        run_op("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
        run_op("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1);
        run_op("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b0);
        run_op("5A/0", 8'h5A, 8'd0, 8'hFF, 8'h5A, dz_exp, 1'b0);
        run_op("9/9", 8'd9, 8'd9, 8'd1, 8'd0, 1'b0, 1'b1);

        // Abort 200/13 with reset in cycle N+4.
        A = 8'd200;
        B = 8'd13;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("abort busy pre", 32'(busy), 32'd1);
        Resetn = 1'b0;
        #1;
        check_all_zero("abort async");
        tick();
        check_all_zero("abort held");
        Resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("abort nodone@%0d", i), 32'(done), 32'd0);
        end
        run_op("200/13", 8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, which sets the operand, quotient and remainder width in bits.
REQ-002 Port Clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port Resetn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Port start  input  1  SHALL be the request strobe, sampled only in IDLE.
REQ-005 Port A  input  WIDTH  SHALL carry the unsigned dividend, captured on the accepting edge.
REQ-006 Port B  input  WIDTH  SHALL carry the unsigned divisor, captured on the accepting edge.
REQ-007 Port busy  output  1  SHALL be high while in RUN.
REQ-008 Port done  output  1  SHALL be a one-cycle pulse marking valid results.
REQ-009 Port quotient  output  WIDTH  SHALL carry the unsigned quotient A/B.
REQ-010 Port remainder  output  WIDTH  SHALL carry the unsigned remainder A mod B.
REQ-011 Port div_by_zero  output  1  SHALL be the divide-by-zero flag (see Configuration).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE -> RUN SHALL occur on an edge where start=1; A and B are latched internally and the iteration counter is cleared.
REQ-014 RUN SHALL perform one restoring step per edge: shift {partial remainder, dividend} left by 1; trial-subtract B using a WIDTH+1-bit difference; if the result is non-negative, keep it and set the quotient LSB to 1, else restore and set it to 0.
REQ-015 RUN -> DONE SHALL occur on the edge completing the WIDTH-th step.
REQ-016 DONE -> IDLE SHALL occur unconditionally after one cycle.
REQ-017 Latency SHALL be fixed: with start sampled high in cycle N, busy is high in cycles N+1..N+WIDTH and done is high only in cycle N+WIDTH+1.
REQ-018 quotient and remainder SHALL update only on the RUN->DONE edge, then hold until the next RUN->DONE edge or reset.
REQ-019 start SHALL be ignored in RUN and DONE; in-flight operands are never disturbed, and start=1 in the DONE cycle does not begin a new operation.
REQ-020 Changes on A or B after the accepting edge SHALL have no effect on the result.
REQ-021 With B=0 and no fast path, the algorithm SHALL naturally yield quotient = all ones and remainder = A.
REQ-022 Edge cases SHALL produce: A<B -> quotient 0, remainder A; A=B (B!=0) -> quotient 1, remainder 0.

Reset
REQ-023 While Resetn=0, the state SHALL be IDLE, and busy, done, quotient, remainder, div_by_zero and all internal registers SHALL be 0, independent of Clock.
REQ-024 Reset asserted mid-RUN SHALL abort the operation without producing a done pulse; the first start accepted after release behaves normally.

Configuration
REQ-025 Macro DIV_ZERO_FAST_EN SHALL select the divide-by-zero behaviour.
REQ-026 With DIV_ZERO_FAST_EN defined, a start accepted with B=0 SHALL go IDLE -> DONE directly: done is high in cycle N+1, quotient = all ones, remainder = A, div_by_zero=1 (held with the results), and busy stays 0.
REQ-027 With DIV_ZERO_FAST_EN defined, div_by_zero SHALL be cleared on the next accepted start with B!=0.
REQ-028 Without DIV_ZERO_FAST_EN, div_by_zero SHALL be tied 0 and B=0 SHALL take the normal WIDTH-cycle path with the REQ-021 values.

Verification (WIDTH=8)
REQ-029 Start with A=100, B=7 in cycle N -> busy high N+1..N+8; done high only at N+9 with quotient=14, remainder=2.
REQ-030 Back-to-back A=255,B=1 then A=5,B=9 -> quotient=255/remainder=0, then quotient=0/remainder=5; start pulses during busy and in the DONE cycle are ignored.
REQ-031 A=0x5A, B=0 -> with macro defined: done at N+1, quotient=0xFF, remainder=0x5A, div_by_zero=1; without the macro: same values at N+9 with div_by_zero=0.
REQ-032 A=200, B=13, Resetn pulsed low during cycle N+4 -> all outputs 0 immediately and no done pulse; a new start with A=200, B=13 -> quotient=15, remainder=5 at nine cycles after acceptance.
REQ-033 A=9, B=9, and A and B changed to 0xFF during RUN -> quotient=1, remainder=0.
